keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the 7-segment display scanner: drives a 4x4 hex keypad row-by-row and reads its columns, where the display scanner drives anodes and writes segments.
- Debounces each key and emits a 4-bit hex code with a one-cycle valid strobe.
- Shifts accepted nibbles into a 16-bit entry register that the top level feeds to the data path (e.g. as DS) and to the display.

Parameters:
- SCAN_DIV, 50000: clk cycles per scan tick (0.5 ms at 100 MHz); legal range ≥4.
- DB_COUNT, 20: consecutive stable scan ticks required for press and for release; legal range ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- col_n  in  4  keypad columns, active-low, asynchronous to clk.
- entry_clr  in  1  synchronous clear of entry.
- row_n  out  4  keypad row drive, one-cold active-low.
- key_code  out  4  hex value of last accepted key.
- key_valid  out  1  one-clk strobe per accepted press.
- key_held  out  1  high while an accepted key is still down.
- entry  out  16  last four accepted nibbles, newest in [3:0].

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low (reset==0 at a rising edge).
- Reset values: row_n=4'b1110, key_code=0, key_valid=0, key_held=0, entry=0. Prescaler, debounce counter and FSM go to SCAN with row index 0.
- Reset asserted mid-press discards the press; no key_valid is issued.
- Input sync: col_n passes through a 2-flop synchronizer (col_s). All decisions use col_s.
- Prescaler: tick pulses one clk every SCAN_DIV clks. All FSM decisions are evaluated only on tick.
- Key map, rows 0..3 x cols 0..3:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: 0 F E D
- "Single key": exactly one bit of col_s is 0. Zero or multiple lows mean no key.
- FSM, SCAN:
  - On tick, single key → latch row/col, clear counter, go to DEBOUNCE. row_n frozen.
  - Otherwise advance row index mod 4 (3→0 wraps).
- FSM, DEBOUNCE:
  - On tick, col_s equals latched pattern → counter++.
  - Counter reaches DB_COUNT → go to PRESSED. key_code=map(row,col); key_valid=1 for exactly one clk; key_held=1; entry updated.
  - On mismatch → SCAN; row advances on the next tick.
- FSM, PRESSED:
  - On tick, col_s==4'hF → clear counter, go to RELEASE.
  - Any other value (including a second key) → stay; no new strobe.
- FSM, RELEASE:
  - On tick, col_s==4'hF → counter++.
  - Counter reaches DB_COUNT → key_held=0; go to SCAN with the row advanced.
  - Any low column → back to PRESSED (bounce); no new strobe.
- Latency: key_valid asserts the clk after the DB_COUNT-th confirming tick, i.e. DB_COUNT+1 ticks after first detection, plus ≤2 clk sync delay.
- Entry update: entry <= {entry[11:0], key_code_new} on key_valid. Oldest nibble is discarded.
- Entry clear: entry_clr → entry=0.
  - Simultaneous entry_clr and key_valid: clear wins; entry=0.
  - key_code and key_valid still update normally.
- key_code holds its value until the next accepted press.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter counts ticks.
  - After REPEAT_DLY ticks (localparam 1000), key_valid re-strobes with the same key_code and entry shifts again.
  - Further strobes follow every REPEAT_RATE ticks (localparam 200).
  - The counter clears on leaving PRESSED.
- Not defined: exactly one key_valid per press; repeat logic absent.

Decomposition:
- Package keypad_pkg:
  - FSM state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}.
  - 16-entry key map constant.
  - Reset row pattern 4'b1110.
  - REPEAT_DLY and REPEAT_RATE.
- Sub-module tick_gen(clk, reset, tick), parameterised by SCAN_DIV; reusable by the display scanner.
- Synchronizer and FSM stay inline.

Test Plan (SCAN_DIV=4, DB_COUNT=3):
- Reset → row_n=1110, entry=0000, key_valid=0, key_held=0. Release reset with no key → row_n cycles 1110→1101→1011→0111→1110, one step per 4 clks.
- Hold col_n=1011 while row_n=1101, clean → row_n freezes at 1101; one key_valid with key_code=6; key_held=1; entry=0006. Release → key_held=0 after 3 clean ticks, scanning resumes.
- Press 1, A, 0, D, 7 in sequence → entry=0001, 001A, 01A0, 1A0D, A0D7. Exactly 5 strobes.
- Bounce: key low for 2 ticks then high → no key_valid, return to SCAN. Release bounce of 1 tick during RELEASE → no second strobe.
- Two columns low together (col_n=1001) → no key_valid. entry_clr coincident with a key_valid for 5 → entry=0000, key_code=5.
- Reset driven low while in DEBOUNCE → all outputs at reset values next clk; no strobe. With KEYPAD_AUTOREPEAT_EN, holding key 8 for 1400 ticks → 3 strobes.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad scanner.
// Latency: n/a (package of constants, types and pure functions).
// Backpressure: n/a.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  // Row drive pattern after reset: row 0 driven low.
  localparam logic [3:0] RST_ROW_N = 4'b1110;

  // Column pattern with no key pulling any column low.
  localparam logic [3:0] COL_IDLE = 4'hF;

  // Auto-repeat timing in scan ticks: first repeat delay, then repeat period.
  localparam int REPEAT_DLY  = 1000;
  localparam int REPEAT_RATE = 200;

  // Key map indexed by {row[1:0], col[1:0]}; element 0 is row 0 / col 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,   // row 3: cols 3..0
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  // One-cold row drive for a row index.
  function automatic logic [3:0] row_cold(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // True when exactly one column is pulled low.
  function automatic logic single_key(input logic [3:0] c);
    case (c)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Column index of the single low bit (only meaningful when single_key is true).
  function automatic logic [1:0] col_index(input logic [3:0] c);
    case (c)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler producing a one-clk tick every SCAN_DIV clks.
// Latency: first tick SCAN_DIV clks after reset release, then periodic.
// Backpressure: none; tick is a pure strobe with no handshake.
module tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Wrap the divider on the tick cycle, otherwise count up.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Divider register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad, debounces, strobes hex codes, shifts them into entry.
// Latency: key_valid one clk after the DB_COUNT-th confirming tick (DB_COUNT+1 ticks after detect) plus 2-clk col sync.
// Backpressure: none; key_valid is a one-clk strobe. Optional KEYPAD_AUTOREPEAT_EN re-strobes a held key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DB_COUNT = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col_n,
  input  logic        entry_clr,
  output logic [3:0]  row_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam int DBW = $clog2(DB_COUNT + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_COUNT);

  logic            tick;
  logic [3:0]      col_s1_q;
  logic [3:0]      col_s_q;
  kp_state_e       state_q,     state_d;
  logic [1:0]      row_q,       row_d;
  logic [3:0]      row_n_q,     row_n_d;
  logic [3:0]      lat_col_q,   lat_col_d;
  logic [DBW-1:0]  db_cnt_q,    db_cnt_d;
  logic [DBW-1:0]  db_inc;
  logic [3:0]      key_code_q,  key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q,  key_held_d;
  logic [15:0]     entry_q,     entry_d;
  logic [3:0]      code_new;
  logic            strobe;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DLY + 1);
  localparam logic [RPT_W-1:0] RPT_DLY_C  = RPT_W'(REPEAT_DLY);
  localparam logic [RPT_W-1:0] RPT_RATE_C = RPT_W'(REPEAT_RATE);

  logic [RPT_W-1:0] rpt_cnt_q,   rpt_cnt_d;
  logic [RPT_W-1:0] rpt_inc;
  logic             rpt_armed_q, rpt_armed_d;
`endif

  tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign db_inc    = db_cnt_q + 1'b1;
  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign entry     = entry_q;

  // Two-flop synchronizer for the asynchronous column inputs; idle is all-high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_s1_q <= COL_IDLE;
      col_s_q  <= COL_IDLE;
    end else begin
      col_s1_q <= col_n;
      col_s_q  <= col_s1_q;
    end
  end

  // Scan/debounce FSM next state; decisions only on tick, strobe drives code and entry.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    lat_col_d   = lat_col_q;
    db_cnt_d    = db_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    entry_d     = entry_q;
    code_new    = key_code_q;
    strobe      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_inc     = rpt_cnt_q + 1'b1;
`endif

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (single_key(col_s_q)) begin
            // Freeze the row and remember which column went low.
            lat_col_d = col_s_q;
            db_cnt_d  = '0;
            state_d   = DEBOUNCE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_s_q == lat_col_q) begin
            if (db_inc == DB_MAX) begin
              db_cnt_d   = '0;
              state_d    = PRESSED;
              key_held_d = 1'b1;
              strobe     = 1'b1;
              code_new   = KEY_MAP[{row_q, col_index(lat_col_q)}];
            end else begin
              db_cnt_d = db_inc;
            end
          end else begin
            // Bounce: scanning resumes, row moves on the following tick.
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (col_s_q == COL_IDLE) begin
            db_cnt_d = '0;
            state_d  = RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else begin
            if (rpt_inc == (rpt_armed_q ? RPT_RATE_C : RPT_DLY_C)) begin
              rpt_cnt_d   = '0;
              rpt_armed_d = 1'b1;
              strobe      = 1'b1;
              code_new    = key_code_q;
            end else begin
              rpt_cnt_d = rpt_inc;
            end
          end
`endif
        end
        RELEASE: begin
          if (col_s_q == COL_IDLE) begin
            if (db_inc == DB_MAX) begin
              db_cnt_d   = '0;
              key_held_d = 1'b0;
              state_d    = SCAN;
              row_d      = row_q + 1'b1;
            end else begin
              db_cnt_d = db_inc;
            end
          end else begin
            // Release bounce: key still considered down, no new strobe.
            state_d = PRESSED;
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    if (state_d != PRESSED) begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end
`endif

    if (strobe) begin
      key_valid_d = 1'b1;
      key_code_d  = code_new;
      entry_d     = {entry_q[11:0], code_new};
    end

    // Clear has priority over a simultaneous shift.
    if (entry_clr) begin
      entry_d = '0;
    end

    row_n_d = row_cold(row_d);
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      row_q       <= '0;
      row_n_q     <= RST_ROW_N;
      lat_col_q   <= COL_IDLE;
      db_cnt_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      entry_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      row_n_q     <= row_n_d;
      lat_col_q   <= lat_col_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      entry_q     <= entry_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Auto-repeat tick counter, only live while a key is held in PRESSED.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`endif

endmodule
